// File: rtl/i2c_data_fifo.sv
// TX/RX byte FIFOs between the APB slave and the I2C bit engine, plus status_reg.
// Define I2C_FIFO_ERR_FLAGS_EN to build the sticky tx_ovf / rx_unf flags.

module i2c_data_fifo_buf #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  rd_en,
    input  logic                  flush,
    output logic [DATA_W-1:0]     rdata,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);
    localparam int                DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                push_ok, pop_ok;

    // Extra MSB on each pointer tells full apart from empty when the low bits match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                     (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign push_ok = wr_en && !full;
    assign pop_ok  = rd_en && !empty;
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; rdata is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wdata;
    end
endmodule

module i2c_data_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  tx_wr_en,
    input  logic [DATA_W-1:0]     tx_wdata,
    input  logic                  tx_rd_en,
    output logic [DATA_W-1:0]     tx_rdata,
    input  logic                  rx_wr_en,
    input  logic [DATA_W-1:0]     rx_wdata,
    input  logic                  rx_rd_en,
    output logic [DATA_W-1:0]     rx_rdata,
    input  logic                  tx_flush,
    input  logic                  rx_flush,
    output logic [DEPTH_LOG2:0]   tx_count,
    output logic [DEPTH_LOG2:0]   rx_count,
    output logic [7:0]            status_reg
);
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_ovf, rx_unf;

    i2c_data_fifo_buf #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_tx (
        .clk(PCLK), .rst_n(PRESETn), .wr_en(tx_wr_en), .wdata(tx_wdata),
        .rd_en(tx_rd_en), .flush(tx_flush), .rdata(tx_rdata), .count(tx_count),
        .full(tx_full), .empty(tx_empty)
    );

    i2c_data_fifo_buf #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_rx (
        .clk(PCLK), .rst_n(PRESETn), .wr_en(rx_wr_en), .wdata(rx_wdata),
        .rd_en(rx_rd_en), .flush(rx_flush), .rdata(rx_rdata), .count(rx_count),
        .full(rx_full), .empty(rx_empty)
    );

`ifdef I2C_FIFO_ERR_FLAGS_EN
    logic tx_ovf_q, tx_ovf_d;
    logic rx_unf_q, rx_unf_d;

    // A drop event in a flush cycle wins over the flush clear.
    always_comb begin
        tx_ovf_d = (tx_flush ? 1'b0 : tx_ovf_q) | (tx_wr_en & tx_full);
        rx_unf_d = (rx_flush ? 1'b0 : rx_unf_q) | (rx_rd_en & rx_empty);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
        end else begin
            tx_ovf_q <= tx_ovf_d;
            rx_unf_q <= rx_unf_d;
        end
    end

    assign tx_ovf = tx_ovf_q;
    assign rx_unf = rx_unf_q;
`else
    assign tx_ovf = 1'b0;
    assign rx_unf = 1'b0;
`endif

    assign status_reg = {tx_full, rx_empty, tx_empty, rx_full, 2'b00, tx_ovf, rx_unf};
endmodule
